frag_splitter: RTL
==================

# frag_splitter

Store-and-forward fragmenter for the fragmentation/aggregation datapath. It accepts a packet as a stream of 32-bit words, each carrying 1–4 valid bytes. It splits the packet into fragments of at most FRAG_WORDS payload words and emits each fragment as a header word followed by the buffered payload. Byte packing is MSB-first (first byte in [31:24]), matching the byte-count/word convention used by the byte-granular aggregation FIFO. This block is the de-aggregating end of that interface.

## Interface
- FRAG_WORDS, 8, maximum payload words per fragment; legal range 1..64
- SEQ_W, 8, packet sequence counter width; fixed at 8 (header field)
- clk  in  1  rising-edge clock
- rst_n  in  1  synchronous, active-low reset; one clock domain, sampled on the rising edge of clk
- din  in  32  input word; valid bytes are left-justified from [31:24]
- din_bytes  in  3  valid bytes in din, 1..4
- din_last  in  1  final beat of the packet
- din_valid  in  1  input beat offered
- din_ready  out  1  block accepts the beat; transfer occurs when din_valid && din_ready
- dout  out  32  header or payload word
- dout_bytes  out  3  valid bytes in dout
- dout_sof  out  1  dout is a fragment header
- dout_eof  out  1  dout is the last payload word of the fragment
- dout_valid  out  1  output beat offered
- dout_ready  in  1  downstream accepts; transfer occurs when dout_valid && dout_ready
- err  out  1  sticky illegal-din_bytes flag; cleared only by reset

## Operation
- FSM has three states: FILL, HDR, DRAIN. Reset state is FILL.
- **FILL**
  - din_ready = 1. Each accepted beat writes buf[wcnt] and adds the beat's byte count to frag_len.
  - The state closes on the accepted beat that has din_last = 1, or on the beat where wcnt == FRAG_WORDS-1.
  - On close: latch last_frag = din_last, latch last_bytes = that beat's byte count, go to HDR.
- **HDR**
  - dout_valid = 1, dout_sof = 1, dout_bytes = 4.
  - Header layout: dout = {pkt_seq[7:0], frag_idx[6:0], last_frag, frag_len[15:0]}.
  - On handshake: rcnt = 0, go to DRAIN.
- **DRAIN**
  - dout = buf[rcnt].
  - dout_bytes = 4 on every word except the final one (rcnt == wcnt_final), which gets last_bytes. dout_eof = 1 on the final word.
  - On the final handshake:
    - if last_frag: pkt_seq += 1 and frag_idx = 0;
    - otherwise frag_idx += 1.
  - Then clear wcnt and frag_len, go to FILL.
- **din_bytes legality**
  - On a non-last beat, din_bytes must be 4.
  - Any illegal value (0, 5..7, or <4 on a non-last beat) sets err. The beat is then treated as 4 bytes.
- **Wrap rules**
  - pkt_seq wraps 255 -> 0.
  - frag_idx wraps 127 -> 0.
  - frag_len is 16 bits and never exceeds 256.
- **Exact-multiple packet**: when din_last arrives on the beat that fills the buffer, that fragment carries last_frag = 1. No empty trailing fragment is ever emitted.
- **Empty-packet rule**: a packet never has zero bytes. din_last with din_bytes = 0 is an error beat and counts as 4 bytes.

## Timing
- **Reset values**: dout = 0, dout_bytes = 0, dout_sof = 0, dout_eof = 0, dout_valid = 0, err = 0. Internally pkt_seq = 0, frag_idx = 0, wcnt = 0, frag_len = 0.
- din_ready = (state == FILL) && rst_n. It is 0 during the reset cycle.
- All dout* outputs are registers. dout_valid rises in the cycle after the fragment-closing input beat is accepted, so the header appears with 1-cycle latency.
- **Throughput**: one beat per cycle at both ports when the other side is ready. Fill and drain do not overlap, so din_ready = 0 throughout HDR and DRAIN.
- **Backpressure**: while dout_valid && !dout_ready, all dout* outputs hold stable. dout_valid never drops without a handshake.
- **Reset mid-operation**: the buffered fragment is discarded and counters are zeroed. The next packet's header has seq 0 and idx 0.

## Structure
- **Shared package frag_pkg** holds:
  - the FSM state enum (FILL, HDR, DRAIN);
  - header field offsets: SEQ [31:24], IDX [23:17], LAST [16], LEN [15:0];
  - a header-pack function;
  - the FRAG_WORDS legal bounds.
- **Sub-module frag_buf**: a FRAG_WORDS x 32 register file with a synchronous write port and a combinational read by index. It is instantiated once. The FSM, counters and err logic stay in the top module.

## Test plan
- 3 full words, din_last on word 3 (FRAG_WORDS = 8) -> header 0x0001000C with sof, then 3 words, eof on the third, dout_bytes = 4 throughout.
- 20 full words -> three fragments:
  - headers 0x00000020, 0x00020020, 0x00050010;
  - payload counts 8, 8, 4;
  - eof on the last word of each fragment.
- 1 full word, then a last beat with din_bytes = 2 -> header 0x00010006; final dout_bytes = 2. Separately, a non-last beat with din_bytes = 3 -> err = 1 (sticky) and the length counts that beat as 4.
- Exactly 8 words with din_last on the 8th -> a single fragment with header 0x00010020 and no following fragment. The next packet's header has seq = 0x01.
- Random dout_ready stalls -> dout* held stable while stalled, din_ready = 0 during HDR/DRAIN, no word lost or duplicated against the scoreboard.
- 256 one-word packets -> the 257th header has seq 0x00. rst_n pulled low mid-DRAIN -> all outputs 0 in the next cycle, and the next packet's header is 0x00010004.

Source files
------------

// File: rtl/frag_splitter_pkg.sv
// rtl/frag_splitter_pkg.sv - shared types, header layout and bounds for the fragmenter
package frag_pkg;

  typedef enum logic [1:0] {
    FILL  = 2'd0,
    HDR   = 2'd1,
    DRAIN = 2'd2
  } state_t;

  localparam int HDR_SEQ_LSB  = 24;
  localparam int HDR_IDX_LSB  = 17;
  localparam int HDR_LAST_BIT = 16;
  localparam int HDR_LEN_LSB  = 0;

  localparam int FRAG_WORDS_MIN = 1;
  localparam int FRAG_WORDS_MAX = 64;

  // Wide enough to hold FRAG_WORDS_MAX, i.e. one past the largest buffer index.
  localparam int IDX_W = 7;

  function automatic logic [31:0] pack_hdr(input logic [7:0]  seq,
                                           input logic [6:0]  idx,
                                           input logic        last,
                                           input logic [15:0] len);
    logic [31:0] h;
    h = '0;
    h[HDR_SEQ_LSB +: 8]  = seq;
    h[HDR_IDX_LSB +: 7]  = idx;
    h[HDR_LAST_BIT]      = last;
    h[HDR_LEN_LSB +: 16] = len;
    return h;
  endfunction

endpackage

// File: rtl/frag_splitter_if.sv
// rtl/frag_splitter_if.sv - input beat stream and output fragment stream of the fragmenter
interface frag_splitter_if;
  logic [31:0] din;
  logic [2:0]  din_bytes;
  logic        din_last;
  logic        din_valid;
  logic        din_ready;
  logic [31:0] dout;
  logic [2:0]  dout_bytes;
  logic        dout_sof;
  logic        dout_eof;
  logic        dout_valid;
  logic        dout_ready;
  logic        err;

  modport slave (
    input  din, din_bytes, din_last, din_valid, dout_ready,
    output din_ready, dout, dout_bytes, dout_sof, dout_eof, dout_valid, err
  );

  modport master (
    output din, din_bytes, din_last, din_valid, dout_ready,
    input  din_ready, dout, dout_bytes, dout_sof, dout_eof, dout_valid, err
  );
endinterface

// File: rtl/frag_splitter_buf.sv
// rtl/frag_splitter_buf.sv - fragment payload register file, sync write, comb read
module frag_buf
  import frag_pkg::*;
#(
  parameter int DEPTH = 8
) (
  input  logic             clk,
  input  logic             wr_en,
  input  logic [IDX_W-1:0] wr_idx,
  input  logic [31:0]      wr_data,
  input  logic [IDX_W-1:0] rd_idx,
  output logic [31:0]      rd_data
);

  logic [31:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    for (int i = 0; i < DEPTH; i++) begin
      if (wr_en && wr_idx == IDX_W'(i)) mem[i] <= wr_data;
    end
  end

  // Out-of-range indices read as zero; the drain side looks one past the end on its final word.
  always_comb begin
    rd_data = '0;
    for (int i = 0; i < DEPTH; i++) begin
      if (rd_idx == IDX_W'(i)) rd_data = mem[i];
    end
  end

endmodule

// File: rtl/frag_splitter.sv
// rtl/frag_splitter.sv - store-and-forward packet fragmenter with header insertion
module frag_splitter
  import frag_pkg::*;
#(
  parameter int FRAG_WORDS = 8,
  parameter int SEQ_W      = 8
) (
  input logic            clk,
  input logic            rst_n,
  frag_splitter_if.slave bus
);

  if (FRAG_WORDS < FRAG_WORDS_MIN || FRAG_WORDS > FRAG_WORDS_MAX) begin : g_bad_depth
    $error("frag_splitter: FRAG_WORDS out of range");
  end

  state_t           state, state_n;
  logic [IDX_W-1:0] wcnt, wcnt_n, rcnt, rcnt_n, rd_idx;
  logic [15:0]      frag_len, frag_len_n, len_sum;
  logic             last_frag, last_frag_n;
  logic [2:0]       last_bytes, last_bytes_n;
  logic [SEQ_W-1:0] pkt_seq, pkt_seq_n;
  logic [6:0]       frag_idx, frag_idx_n;
  logic             err_q, err_n;
  logic [31:0]      out_data, out_data_n, rd_data;
  logic [2:0]       out_bytes, out_bytes_n;
  logic             out_sof, out_sof_n, out_eof, out_eof_n, out_valid, out_valid_n;
  logic             accept, beat_ok, closing;
  logic [2:0]       eff_bytes;

  assign bus.din_ready  = (state == FILL) && rst_n;
  assign bus.dout       = out_data;
  assign bus.dout_bytes = out_bytes;
  assign bus.dout_sof   = out_sof;
  assign bus.dout_eof   = out_eof;
  assign bus.dout_valid = out_valid;
  assign bus.err        = err_q;

  assign accept = bus.din_valid && bus.din_ready;

  // Only the packet's last beat may be partial; anything else is flagged and counted as full.
  always_comb begin
    beat_ok   = bus.din_last ? (bus.din_bytes >= 3'd1 && bus.din_bytes <= 3'd4)
                             : (bus.din_bytes == 3'd4);
    eff_bytes = beat_ok ? bus.din_bytes : 3'd4;
    closing   = bus.din_last || (wcnt == IDX_W'(FRAG_WORDS - 1));
    len_sum   = frag_len + 16'(eff_bytes);
  end

  frag_buf #(.DEPTH(FRAG_WORDS)) u_buf (
    .clk     (clk),
    .wr_en   (accept),
    .wr_idx  (wcnt),
    .wr_data (bus.din),
    .rd_idx  (rd_idx),
    .rd_data (rd_data)
  );

  always_comb begin
    state_n      = state;
    wcnt_n       = wcnt;
    rcnt_n       = rcnt;
    frag_len_n   = frag_len;
    last_frag_n  = last_frag;
    last_bytes_n = last_bytes;
    pkt_seq_n    = pkt_seq;
    frag_idx_n   = frag_idx;
    err_n        = err_q;
    out_data_n   = out_data;
    out_bytes_n  = out_bytes;
    out_sof_n    = out_sof;
    out_eof_n    = out_eof;
    out_valid_n  = out_valid;
    rd_idx       = '0;
    unique case (state)
      FILL: begin
        if (accept) begin
          if (!beat_ok) err_n = 1'b1;
          frag_len_n = len_sum;
          if (closing) begin
            last_frag_n  = bus.din_last;
            last_bytes_n = eff_bytes;
            state_n      = HDR;
            out_data_n   = pack_hdr(pkt_seq, frag_idx, bus.din_last, len_sum);
            out_bytes_n  = 3'd4;
            out_sof_n    = 1'b1;
            out_eof_n    = 1'b0;
            out_valid_n  = 1'b1;
          end else begin
            wcnt_n = wcnt + 1'b1;
          end
        end
      end
      HDR: begin
        if (bus.dout_ready) begin
          rcnt_n      = '0;
          state_n     = DRAIN;
          out_data_n  = rd_data;
          out_bytes_n = (wcnt == '0) ? last_bytes : 3'd4;
          out_sof_n   = 1'b0;
          out_eof_n   = (wcnt == '0);
        end
      end
      DRAIN: begin
        // Prefetch the word after the one on dout so the next handshake can load it.
        rd_idx = rcnt + 1'b1;
        if (bus.dout_ready) begin
          if (rcnt == wcnt) begin
            if (last_frag) begin
              pkt_seq_n  = pkt_seq + 1'b1;
              frag_idx_n = '0;
            end else begin
              frag_idx_n = frag_idx + 1'b1;
            end
            wcnt_n      = '0;
            frag_len_n  = '0;
            state_n     = FILL;
            out_data_n  = '0;
            out_bytes_n = '0;
            out_eof_n   = 1'b0;
            out_valid_n = 1'b0;
          end else begin
            rcnt_n      = rcnt + 1'b1;
            out_data_n  = rd_data;
            out_bytes_n = ((rcnt + 1'b1) == wcnt) ? last_bytes : 3'd4;
            out_eof_n   = ((rcnt + 1'b1) == wcnt);
          end
        end
      end
      default: state_n = FILL;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state      <= FILL;
      wcnt       <= '0;
      rcnt       <= '0;
      frag_len   <= '0;
      last_frag  <= 1'b0;
      last_bytes <= '0;
      pkt_seq    <= '0;
      frag_idx   <= '0;
      err_q      <= 1'b0;
      out_data   <= '0;
      out_bytes  <= '0;
      out_sof    <= 1'b0;
      out_eof    <= 1'b0;
      out_valid  <= 1'b0;
    end else begin
      state      <= state_n;
      wcnt       <= wcnt_n;
      rcnt       <= rcnt_n;
      frag_len   <= frag_len_n;
      last_frag  <= last_frag_n;
      last_bytes <= last_bytes_n;
      pkt_seq    <= pkt_seq_n;
      frag_idx   <= frag_idx_n;
      err_q      <= err_n;
      out_data   <= out_data_n;
      out_bytes  <= out_bytes_n;
      out_sof    <= out_sof_n;
      out_eof    <= out_eof_n;
      out_valid  <= out_valid_n;
    end
  end

endmodule
